// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution filter-side blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   CONV_SLICE(vec, idx, w) : selects element idx of width w from a packed bus.
//   state_t                 : arbiter state encoding (IDLE, LOCKED).
//   clog2(value)            : ceil(log2(value)), never less than 1.

`define CONV_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package conv_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Returns at least 1 so that it can size a counter or pointer directly.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: picks the first asserted req at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
//   req  [N]     : request vector
//   ptr  [PTR_W] : highest-priority index for this arbitration
//   pick [N]     : one-hot winner (all zero when vld=0)
//   vld          : at least one request present

module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             vld
);

    // Candidate index for each search step, (ptr + k) mod N.
    logic [PTR_W-1:0] cand [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            cand[k] = PTR_W'((int'(ptr) + k) % N);
        end
    end

    always_comb begin
        pick = '0;
        vld  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!vld && req[cand[k]]) begin
                vld            = 1'b1;
                pick[cand[k]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_wr_arbiter.sv
// Round-robin arbiter sharing the output-memory write port between filter controllers.
// Latency: req to gnt 1 cycle; one IDLE bubble between bursts; beat passes through combinationally.
// Backpressure: mem_ready=0 stalls the beat and holds the grant; other requesters wait in IDLE queue.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req, last           : per-requester burst request / final-beat flag
//   addr, data          : packed per-requester address and data
//   mem_ready           : memory accepts the presented beat
//   gnt                 : registered one-hot grant
//   mem_wr/addr/data    : write beat of the granted requester (zero when not locked)
//   busy                : a grant is held
//   err                 : one-cycle pulse on an aborted or overlong burst

module conv_wr_arbiter
    import conv_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        last,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] data,
    input  logic                    mem_ready,
    output logic [N_REQ-1:0]        gnt,
    output logic                    mem_wr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_data,
    output logic                    busy,
    output logic                    err
);

    localparam int PTR_W = clog2(N_REQ);
    localparam int CNT_W = clog2(BURST_MAX + 1);

    // Count value before the beat that fills the burst.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_MAX - 1);
    localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(N_REQ - 1);

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic [N_REQ-1:0] pick;
    logic             pick_vld;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] next_ptr;
    logic             req_g;
    logic             last_g;
    logic             accept;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick),
        .vld  (pick_vld)
    );

    // Binary index of the held grant; zero when no grant.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    // The just-served requester drops to lowest priority.
    assign next_ptr = (gnt_idx == PTR_TOP) ? '0 : gnt_idx + 1'b1;

    assign req_g  = req[gnt_idx];
    assign last_g = last[gnt_idx];
    assign accept = (state == LOCKED) && req_g && mem_ready;
    assign busy   = (state == LOCKED);

    always_comb begin
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (state == LOCKED) begin
            mem_wr   = req_g;
            mem_addr = `CONV_SLICE(addr, gnt_idx, ADDR_W);
            mem_data = `CONV_SLICE(data, gnt_idx, DATA_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= LOCKED;
                        gnt      <= pick;
                        beat_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (!req_g) begin
                        // Requester withdrew mid-burst: release and flag the abort.
                        state    <= IDLE;
                        gnt      <= '0;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                        err      <= 1'b1;
                    end else if (accept) begin
                        if (last_g) begin
                            state    <= IDLE;
                            gnt      <= '0;
                            rr_ptr   <= next_ptr;
                            beat_cnt <= '0;
                        end else if (beat_cnt == CNT_FULL) begin
                            // Burst hit its beat limit without a last flag: cut it.
                            state    <= IDLE;
                            gnt      <= '0;
                            rr_ptr   <= next_ptr;
                            beat_cnt <= '0;
                            err      <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= '0;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_wr_arbiter.sv
module tb_conv_wr_arbiter;

    localparam int N    = 4;
    localparam int AW   = 6;
    localparam int DW   = 16;
    localparam int BMAX = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N-1:0]      last;
    logic [N*AW-1:0]   addr;
    logic [N*DW-1:0]   data;
    logic              mem_ready;
    logic [N-1:0]      gnt;
    logic              mem_wr;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit cmp_en = 0;

    conv_wr_arbiter #(
        .N_REQ     (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_MAX (BMAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .addr      (addr),
        .data      (data),
        .mem_ready (mem_ready),
        .gnt       (gnt),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: who owns the port, whose turn it is, beats so far.
    typedef struct packed {
        bit locked;
        int owner;
        int ptr;
        int beats;
        bit err;
    } model_t;

    model_t m = '0;

    function automatic model_t model_step(input model_t s, input logic [N-1:0] r,
                                          input logic [N-1:0] l, input logic rdy);
        model_t n;
        bit release_now;
        n = s;
        n.err = 1'b0;
        release_now = 1'b0;
        if (!s.locked) begin
            for (int k = 0; k < N; k++) begin
                if (!n.locked && r[(s.ptr + k) % N]) begin
                    n.locked = 1'b1;
                    n.owner  = (s.ptr + k) % N;
                    n.beats  = 0;
                end
            end
        end else if (!r[s.owner]) begin
            release_now = 1'b1;
            n.err = 1'b1;
        end else if (rdy) begin
            n.beats = s.beats + 1;
            if (l[s.owner]) begin
                release_now = 1'b1;
            end else if (n.beats == BMAX) begin
                release_now = 1'b1;
                n.err = 1'b1;
            end
        end
        if (release_now) begin
            n.locked = 1'b0;
            n.ptr    = (s.owner + 1) % N;
            n.beats  = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, req, last, mem_ready);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [N-1:0]  e_gnt;
            logic          e_wr;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_data;
            e_gnt  = m.locked ? N'(1 << m.owner) : '0;
            e_wr   = m.locked && req[m.owner];
            e_addr = m.locked ? addr[m.owner*AW +: AW] : '0;
            e_data = m.locked ? data[m.owner*DW +: DW] : '0;
            chk("cyc_gnt",  32'(gnt),      32'(e_gnt));
            chk("cyc_busy", 32'(busy),     32'(m.locked));
            chk("cyc_wr",   32'(mem_wr),   32'(e_wr));
            chk("cyc_addr", 32'(mem_addr), 32'(e_addr));
            chk("cyc_data", 32'(mem_data), 32'(e_data));
            chk("cyc_err",  32'(err),      32'(m.err));
        end
    end

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy,
                        input bit hold = 1'b0);
        @(posedge clk);
        #2;
        cyc++;
        req       = r;
        last      = l;
        mem_ready = rdy;
        if (!hold) begin
            for (int i = 0; i < N; i++) begin
                addr[i*AW +: AW] = AW'(cyc * 5 + i);
                data[i*DW +: DW] = DW'(32'h1000 * (i + 1) + cyc);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    logic [N-1:0] t3_exp [10];

    initial begin
        t3_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                   4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        rst_n = 1'b0;
        req = '0; last = '0; addr = '0; data = '0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        // T1: reset in the middle of a burst owned by requester 1.
        step(4'b0010, 4'b0000, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t1_gnt_before", 32'(gnt), 32'h2);
        step(4'b0010, 4'b0000, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_gnt_rst",  32'(gnt),        32'h0);
        chk("t1_wr_rst",   32'(mem_wr),     32'h0);
        chk("t1_busy_rst", 32'(busy),       32'h0);
        chk("t1_ptr_rst",  32'(dut.rr_ptr), 32'h0);
        req = '0; last = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // T3: everyone requesting, single-beat bursts.
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 4'b1111, 1'b1);
            @(negedge clk);
            chk($sformatf("t3_gnt_%0d", i), 32'(gnt), 32'(t3_exp[i]));
        end
        step(4'b0000, 4'b0000, 1'b1);

        // T2: requester 0, three-beat burst.
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t2_gnt",  32'(gnt),      32'h1);
        chk("t2_wr",   32'(mem_wr),   32'h1);
        chk("t2_addr", 32'(mem_addr), 32'(AW'(cyc * 5)));
        chk("t2_data", 32'(mem_data), 32'(DW'(32'h1000 + cyc)));
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0001, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t2_gnt_end", 32'(gnt),        32'h0);
        chk("t2_ptr",     32'(dut.rr_ptr), 32'h1);
        chk("t2_err",     32'(err),        32'h0);

        // T4: memory stalls the second beat for five cycles, last held meanwhile.
        step(4'b0001, 4'b0000, 1'b1);
        step(4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, 4'b0001, 1'b0, 1'b1);
            @(negedge clk);
            chk($sformatf("t4_gnt_%0d", i), 32'(gnt),          32'h1);
            chk($sformatf("t4_cnt_%0d", i), 32'(dut.beat_cnt), 32'h1);
            chk($sformatf("t4_err_%0d", i), 32'(err),          32'h0);
        end
        step(4'b0001, 4'b0001, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t4_err_end", 32'(err), 32'h0);
        chk("t4_gnt_end", 32'(gnt), 32'h0);

        // T5: requester 0 runs four beats with no last; requester 1 waits.
        step(4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(4'b0011, 4'b0000, 1'b1);
            @(negedge clk);
            chk($sformatf("t5_gnt_%0d", i), 32'(gnt), 32'h1);
        end
        step(4'b0010, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t5_err_pulse", 32'(err), 32'h1);
        chk("t5_gnt_idle",  32'(gnt), 32'h0);
        step(4'b0010, 4'b0010, 1'b1);
        @(negedge clk);
        chk("t5_gnt_next",  32'(gnt), 32'h2);
        chk("t5_err_clear", 32'(err), 32'h0);
        step(4'b0000, 4'b0000, 1'b1);

        // T6: requester 2 drops its request after one beat.
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t6_gnt", 32'(gnt), 32'h4);
        step(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t6_wr_drop", 32'(mem_wr), 32'h0);
        step(4'b1111, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t6_err", 32'(err),        32'h1);
        chk("t6_ptr", 32'(dut.rr_ptr), 32'h3);
        step(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("t6_gnt_next", 32'(gnt), 32'h8);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
